// File: rtl/alu_muldiv_control_pkg.sv
// Shared encodings for the ALU control decoder and the mul/div engine.
//   - ALU_OP_*  : ALUControl codes seen by the datapath ALU
//   - FUNCT_*   : R-type funct field values, including HI/LO and mul/div ops
//   - alu_decode  : ALUOp/funct -> ALUControl code plus illegal flag
//   - md_classify : ALUOp/funct -> HI/LO / mul/div operation class
package alu_muldiv_control_pkg;

  localparam logic [3:0] ALU_OP_AND = 4'h0;
  localparam logic [3:0] ALU_OP_OR  = 4'h1;
  localparam logic [3:0] ALU_OP_ADD = 4'h2;
  localparam logic [3:0] ALU_OP_XOR = 4'h3;
  localparam logic [3:0] ALU_OP_SLL = 4'h4;
  localparam logic [3:0] ALU_OP_SRL = 4'h5;
  localparam logic [3:0] ALU_OP_SUB = 4'h6;
  localparam logic [3:0] ALU_OP_SLT = 4'h7;
  localparam logic [3:0] ALU_OP_SRA = 4'h8;
  localparam logic [3:0] ALU_OP_NOR = 4'hC;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
  } dec_t;

  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  } md_op_t;

  function automatic dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    dec_t d;
    d.ctrl    = ALU_OP_AND;
    d.illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: d.ctrl = ALU_OP_ADD;
      ALUOP_SUB: d.ctrl = ALU_OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_JR,
          FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO,
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: d.ctrl = ALU_OP_ADD;
          FUNCT_SUB: d.ctrl = ALU_OP_SUB;
          FUNCT_AND: d.ctrl = ALU_OP_AND;
          FUNCT_OR:  d.ctrl = ALU_OP_OR;
          FUNCT_XOR: d.ctrl = ALU_OP_XOR;
          FUNCT_NOR: d.ctrl = ALU_OP_NOR;
          FUNCT_SLT: d.ctrl = ALU_OP_SLT;
          FUNCT_SLL: d.ctrl = ALU_OP_SLL;
          FUNCT_SRL: d.ctrl = ALU_OP_SRL;
          FUNCT_SRA: d.ctrl = ALU_OP_SRA;
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic md_op_t md_classify(input logic [1:0] alu_op, input logic [5:0] funct);
    md_op_t m;
    m = MD_NONE;
    if (alu_op == ALUOP_RTYPE) begin
      case (funct)
        FUNCT_MULT:  m = MD_MULT;
        FUNCT_MULTU: m = MD_MULTU;
        FUNCT_DIV:   m = MD_DIV;
        FUNCT_DIVU:  m = MD_DIVU;
        FUNCT_MTHI:  m = MD_MTHI;
        FUNCT_MTLO:  m = MD_MTLO;
        default:     m = MD_NONE;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_muldiv_control_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine (one step per clock, WIDTH steps).
// Operands are converted to magnitudes at start; signs are re-applied on the
// hi/lo outputs, which are valid while done is high.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start         : load operands and begin (ignored while the result is pending)
//   is_signed     : MULT/DIV (1) vs MULTU/DIVU (0)
//   is_div        : divide (1) vs multiply (0)
//   a, b          : multiplicand/dividend, multiplier/divisor
//   done          : one-cycle pulse after the final step
//   hi, lo        : product {hi,lo}, or remainder (hi) / quotient (lo)
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc;      // partial product high half / partial remainder
  logic [WIDTH-1:0]   lo_reg;   // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0]   opnd;     // multiplicand / divisor magnitude
  logic [CNT_W-1:0]   count;
  logic               running;
  logic               div_r;
  logic               neg_res;  // product or quotient is negative
  logic               neg_r;    // remainder is negative

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   sub_rem;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    mag_a    = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b    = (is_signed && b[WIDTH-1]) ? -b : b;
    add_sum  = {1'b0, acc} + {1'b0, opnd};
    shifted  = {acc, lo_reg[WIDTH-1]};
    fits     = (shifted >= {1'b0, opnd});
    sub_rem  = WIDTH'(shifted - {1'b0, opnd});
    prod     = {acc, lo_reg};
    prod_fix = neg_res ? -prod : prod;
    hi       = div_r ? (neg_r ? -acc : acc) : prod_fix[2*WIDTH-1:WIDTH];
    lo       = div_r ? (neg_res ? -lo_reg : lo_reg) : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      lo_reg  <= '0;
      opnd    <= '0;
      count   <= '0;
      running <= 1'b0;
      div_r   <= 1'b0;
      neg_res <= 1'b0;
      neg_r   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !running) begin
        acc     <= '0;
        lo_reg  <= mag_a;
        opnd    <= mag_b;
        count   <= '0;
        running <= 1'b1;
        div_r   <= is_div;
        neg_res <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r   <= is_signed & a[WIDTH-1];
      end else if (running) begin
        if (div_r) begin
          // Restoring step: shift in next dividend bit, subtract if it fits.
          acc    <= fits ? sub_rem : shifted[WIDTH-1:0];
          lo_reg <= {lo_reg[WIDTH-2:0], fits};
        end else if (lo_reg[0]) begin
          acc    <= add_sum[WIDTH:1];
          lo_reg <= {add_sum[0], lo_reg[WIDTH-1:1]};
        end else begin
          acc    <= {1'b0, acc[WIDTH-1:1]};
          lo_reg <= {acc[0], lo_reg[WIDTH-1:1]};
        end
        count <= count + 1'b1;
        if (count == CNT_W'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_control.sv
// ALU control decoder with HI/LO registers and an iterative mul/div engine.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   valid_in        : ALUOp/funct/src_a/src_b valid this cycle
//   ALUOp, funct    : main-control ALU op and R-type funct field
//   src_a, src_b    : rs / rt operands
//   ALUControl      : registered ALU operation code
//   ctrl_valid      : pulse, ALUControl updated
//   illegal         : pulse, unknown funct or ALUOp=11
//   stall           : valid_in while the engine is busy
//   busy            : engine running
//   done            : pulse, hi/lo updated by mul/div
//   div_by_zero     : sticky until the next accepted mul/div
//   hi, lo          : HI/LO registers
module alu_muldiv_control
  import alu_muldiv_control_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              ctrl_valid,
  output logic              illegal,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic             accept;
  dec_t             dec;
  md_op_t           md;
  logic             md_is_div;
  logic             md_signed;
  logic             md_start;
  logic             div_zero;
  logic             eng_start;
  logic             eng_done;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;

  assign busy  = (state == ST_RUN);
  assign stall = valid_in & busy;

  always_comb begin
    accept    = valid_in & ~busy;
    dec       = alu_decode(ALUOp, funct);
    md        = md_classify(ALUOp, funct);
    md_is_div = (md == MD_DIV) || (md == MD_DIVU);
    md_signed = (md == MD_MULT) || (md == MD_DIV);
    md_start  = accept && ((md == MD_MULT) || (md == MD_MULTU) || md_is_div);
    div_zero  = md_is_div && (src_b == '0);
    eng_start = md_start && !div_zero;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .is_signed (md_signed),
    .is_div    (md_is_div),
    .a         (src_a),
    .b         (src_b),
    .done      (eng_done),
    .hi        (eng_hi),
    .lo        (eng_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ALUControl  <= '0;
      ctrl_valid  <= 1'b0;
      illegal     <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      ctrl_valid <= accept;
      illegal    <= accept & dec.illegal;
      done       <= 1'b0;
      if (accept) ALUControl <= CTRL_W'(dec.ctrl);
      if (accept && md == MD_MTHI) hi <= src_a;
      if (accept && md == MD_MTLO) lo <= src_a;
      if (md_start) div_by_zero <= div_zero;

      case (state)
        ST_RUN: begin
          if (eng_done) begin
            hi    <= eng_hi;
            lo    <= eng_lo;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept; divide by zero bypasses the engine.
          if (md_start) begin
            if (div_zero) begin
              hi    <= src_a;
              lo    <= '1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
